// File: rtl/stack_pkg.sv
// Shared types and defaults for the LIFO stack datapath and its drain reader.
package stack_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;
  localparam int unsigned DEFAULT_DEPTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] stack_word_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } drain_state_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready FIFO; head is presented directly from storage registers.
module stream_buf2 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             push;
  logic             pop;

  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push      = in_valid && ((occ != 2'd2) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/stack_drain_reader.sv
// Pops every entry off the LIFO stack on start and streams them out top-first.
module stack_drain_reader
  import stack_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stk_empty,
  input  logic [WIDTH-1:0] stk_data,
  output logic             stk_pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  drain_state_t state;
  logic         inflight;
  logic [1:0]   occ;
  logic         xfer;
  logic [2:0]   occ_next;
  logic         drain_exit;
  logic         pop_ok;

  stream_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (stk_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
  );

  assign xfer = out_valid && out_ready;

  // stk_pop is registered, so the pop rule is applied to the values the
  // state will hold next cycle: inflight then equals today's stk_pop and the
  // buffer occupancy includes today's capture and transfer.
  always_comb begin
    occ_next   = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    drain_exit = (stk_empty && !inflight && !stk_pop) || (count == CNT_W'(DEPTH));
    pop_ok     = !stk_pop && !stk_empty && (count < CNT_W'(DEPTH)) && (occ_next < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stk_pop  <= 1'b0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      stk_pop  <= 1'b0;
      done     <= 1'b0;
      inflight <= stk_pop;
      if (stk_pop) begin
        count <= count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= DRAIN;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            state <= FLUSH;
          end else begin
            stk_pop <= pop_ok;
          end
        end
        FLUSH: begin
          // A pop issued at the depth cap may still be landing in the buffer.
          if ((occ == 2'd0) && !inflight) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_drain_reader.sv
// Directed and randomized drains of a behavioural LIFO, checked against a top-first reference order.
module tb_stack_drain_reader;
  import stack_pkg::*;

  localparam int unsigned W  = DEFAULT_WIDTH;
  localparam int unsigned D  = DEFAULT_DEPTH;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stk_empty;
  logic [W-1:0]  stk_data;
  logic          stk_pop;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  stack_drain_reader #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stk_empty (stk_empty),
    .stk_data  (stk_data),
    .stk_pop   (stk_pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  stack_word_t stk[$];   // index 0 is the bottom, last element is the top
  stack_word_t got[$];
  stack_word_t head_exp;
  int cyc = 0;
  int start_cyc, pops, xfers, dones, valids, done_at;
  int first_pop, last_pop, min_gap, max_out, busy_bad;
  int hold_left, hold_pops, hold_valids, head_bad;
  bit ready_rand, tracking;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    got.delete();
    pops = 0; xfers = 0; dones = 0; valids = 0; done_at = -1;
    first_pop = -1; last_pop = -1; min_gap = 1000; max_out = 0; busy_bad = 0;
    hold_pops = 0; hold_valids = 0; head_bad = 0;
  endtask

  // One clock cycle: observe DUT outputs at the falling edge, then play the
  // stack and the downstream consumer for the next rising edge.
  task automatic step();
    bit in_hold;
    @(negedge clk);
    cyc++;
    in_hold = (hold_left > 0);
    if (in_hold) begin
      out_ready = 1'b0;
      hold_left--;
    end else if (ready_rand) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid) valids++;
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      xfers++;
    end
    if (stk_pop) begin
      pops++;
      if (last_pop >= 0 && cyc - last_pop < min_gap) min_gap = cyc - last_pop;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (stk.size() > 0) stk_data = stk.pop_back();
      else stk_data = 'x;
      stk_empty = (stk.size() == 0);
    end
    if (in_hold) begin
      hold_pops = pops;
      if (out_valid) begin
        hold_valids++;
        if (out_data !== head_exp) head_bad++;
      end
    end
    if (pops - xfers > max_out) max_out = pops - xfers;
    if (tracking && !done && !busy) busy_bad++;
    if (done) begin
      dones++;
      if (done_at < 0) done_at = cyc;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stk_pop"},   32'(stk_pop),   32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
  endtask

  task automatic load_random(input int n);
    stk.delete();
    for (int i = 0; i < n; i++) stk.push_back(stack_word_t'($urandom_range(0, 63)));
    stk_empty = (stk.size() == 0);
  endtask

  task automatic drain(input string tag, input bit rnd, input int hold, input bit poke);
    stack_word_t exp[$];
    stack_word_t g;
    int n;
    int left;
    for (int i = int'(stk.size()) - 1; i >= 0 && exp.size() < D; i--) exp.push_back(stk[i]);
    left = stk.size() - exp.size();
    reset_stats();
    ready_rand = rnd;
    hold_left  = hold;
    head_exp   = (exp.size() > 0) ? exp[0] : '0;
    start_cyc  = cyc;
    start      = 1'b1;
    tracking   = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (dones == 0 && n < 400) begin
      start = poke && (n == 1 || n == 5);
      step();
      n++;
    end
    start    = 1'b0;
    tracking = 1'b0;
    check({tag, "_done_seen"}, 32'(dones), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(count), 32'(exp.size()));
    if (hold > 0) begin
      check({tag, "_held_pops"}, 32'(hold_pops), 32'd2);
      check({tag, "_held_valid"}, 32'(hold_valids > 0), 32'd1);
      check({tag, "_held_head"}, 32'(head_bad), 32'd0);
    end
    repeat (3) step();
    check({tag, "_single_done"}, 32'(dones), 32'd1);
    check({tag, "_count_hold"}, 32'(count), 32'(exp.size()));
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
    check({tag, "_n_out"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 'x;
      check($sformatf("%s_out%0d", tag, i), 32'(g), 32'(exp[i]));
    end
    check({tag, "_pops"}, 32'(pops), 32'(exp.size()));
    check({tag, "_stack_left"}, 32'(stk.size()), 32'(left));
    check({tag, "_pop_gap"}, 32'(min_gap >= 2), 32'd1);
    check({tag, "_occ_bound"}, 32'(max_out <= 2), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    stk_data = '0; stk_empty = 1'b1;
    hold_left = 0; ready_rand = 1'b0; tracking = 1'b0;
    reset_stats();
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Three entries, 12 on top, consumer always ready.
    stk.delete();
    stk.push_back(6'd3); stk.push_back(6'd7); stk.push_back(6'd12);
    stk_empty = 1'b0;
    drain("t1", 1'b0, 0, 1'b0);
    check("t1_pop_spacing", 32'(last_pop - first_pop), 32'(2 * (pops - 1)));

    // Empty stack.
    stk.delete();
    stk_empty = 1'b1;
    drain("t2", 1'b0, 0, 1'b0);
    check("t2_done_latency", 32'(done_at - start_cyc), 32'd3);
    check("t2_no_valid", 32'(valids), 32'd0);

    // Full stack 1..8 with the consumer stalled for the first 20 cycles.
    stk.delete();
    for (int i = 1; i <= 8; i++) stk.push_back(stack_word_t'(i));
    stk_empty = 1'b0;
    drain("t3", 1'b0, 20, 1'b0);

    // Five entries under random backpressure.
    load_random(5);
    drain("t4", 1'b1, 0, 1'b0);

    // Reset after two pops, then drain what is left.
    load_random(6);
    reset_stats();
    ready_rand = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (pops < 2 && n < 50) begin
      step();
      n++;
    end
    check("t5_two_pops", 32'(pops), 32'd2);
    rst = 1'b1;
    step();
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    repeat (4) step();
    check("t5_no_more_pops", 32'(pops), 32'd2);
    check("t5_stack_left", 32'(stk.size()), 32'd4);
    drain("t5b", 1'b1, 0, 1'b0);

    // Start pulses while busy must be ignored.
    load_random(5);
    drain("t6", 1'b1, 0, 1'b1);

    // Random depths, including above the cap.
    for (int r = 0; r < 4; r++) begin
      load_random(int'($urandom_range(0, 11)));
      drain($sformatf("rnd%0d", r), 1'b1, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
